// File: rtl/core_sleep_ctrl.sv
// core_sleep_ctrl: sequences the core clock enable around WFI sleep.
// The core drains, stays idle, and is gated. It resumes on an irq or a
// debug request, with a settle window before the core is released.
//
// Ports:
//   clk_i          free-running cluster clock
//   rst_i          asynchronous reset, active-high
//   fetch_enable_i boot enable, only looked at in BOOT
//   sleep_req_i    WFI sleep request (level)
//   pipe_idle_i    pipeline empty and no bus traffic outstanding
//   irq_pending_i  enabled interrupt pending (level)
//   debug_req_i    debug halt request (level)
//   cnt_clr_i      synchronous clear of sleep_cnt_o
//   clock_en_o     enable to the clock-gating cell (flop output)
//   core_sleep_o   core held / asleep indicator (flop output)
//   wake_cause_o   {debug, irq} captured on the SLEEP->WAKE transition
//   sleep_cnt_o    saturating count of cycles spent in SLEEP
module core_sleep_ctrl #(
    parameter int unsigned IDLE_CYCLES = 4,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fetch_enable_i,
    input  logic                 sleep_req_i,
    input  logic                 pipe_idle_i,
    input  logic                 irq_pending_i,
    input  logic                 debug_req_i,
    input  logic                 cnt_clr_i,
    output logic                 clock_en_o,
    output logic                 core_sleep_o,
    output logic [1:0]           wake_cause_o,
    output logic [CNT_WIDTH-1:0] sleep_cnt_o
);

    localparam int unsigned MAX_CYC =
        (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [CNT_WIDTH-1:0] SLP_ONE = CNT_WIDTH'(1);

    localparam logic [2:0] ST_BOOT  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_SLEEP = 3'd3;
    localparam logic [2:0] ST_WAKE  = 3'd4;

    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_clock_en;
    logic                 r_core_sleep;
    logic [1:0]           r_wake_cause;
    logic [CNT_WIDTH-1:0] r_sleep_cnt;

    logic [2:0]           w_next_state;
    logic [CW-1:0]        w_next_cnt;
    logic                 w_wake;
    logic                 w_cnt_zero;
    logic                 w_in_sleep;
    logic                 w_sleep_cnt_max;
    logic                 w_next_clock_en;
    logic                 w_next_core_sleep;

    assign w_wake          = irq_pending_i | debug_req_i;
    assign w_cnt_zero      = (r_cnt == '0);
    assign w_in_sleep      = (r_state == ST_SLEEP);
    assign w_sleep_cnt_max = &r_sleep_cnt;

    // Next-state and down-counter. The counter is shared between the
    // idle-run qualification in DRAIN and the settle window in WAKE.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        unique case (r_state)
            ST_BOOT: begin
                if (fetch_enable_i) begin
                    w_next_state = ST_WAKE;
                    w_next_cnt   = WAKE_LOAD;
                end
            end
            ST_RUN: begin
                // A sleep request racing a wake source is dropped.
                if (sleep_req_i && !w_wake) begin
                    w_next_state = ST_DRAIN;
                    w_next_cnt   = IDLE_LOAD;
                end
            end
            ST_DRAIN: begin
                if (w_wake || !sleep_req_i) begin
                    w_next_state = ST_RUN;
                end else if (!pipe_idle_i) begin
                    // Idle run must be consecutive; restart it.
                    w_next_cnt = IDLE_LOAD;
                end else if (w_cnt_zero) begin
                    w_next_state = ST_SLEEP;
                end else begin
                    w_next_cnt = r_cnt - CNT_ONE;
                end
            end
            ST_SLEEP: begin
                if (w_wake) begin
                    w_next_state = ST_WAKE;
                    w_next_cnt   = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Requests are not looked at here; RUN handles them.
                if (w_cnt_zero) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_cnt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_next_state = ST_BOOT;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Output flops load the decode of the next state so they move on
    // the same edge as r_state with no input-to-output path.
    always_comb begin
        w_next_clock_en   = (w_next_state == ST_RUN)
                          | (w_next_state == ST_DRAIN)
                          | (w_next_state == ST_WAKE);
        w_next_core_sleep = (w_next_state == ST_BOOT)
                          | (w_next_state == ST_SLEEP)
                          | (w_next_state == ST_WAKE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_BOOT;
            r_cnt        <= '0;
            r_clock_en   <= 1'b0;
            r_core_sleep <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_clock_en   <= w_next_clock_en;
            r_core_sleep <= w_next_core_sleep;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wake_cause <= 2'b00;
        end else if (w_in_sleep && w_wake) begin
            r_wake_cause <= {debug_req_i, irq_pending_i};
        end
    end

    // Clear wins over increment; the count sticks at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sleep_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_sleep_cnt <= '0;
        end else if (w_in_sleep && !w_sleep_cnt_max) begin
            r_sleep_cnt <= r_sleep_cnt + SLP_ONE;
        end
    end

    assign clock_en_o   = r_clock_en;
    assign core_sleep_o = r_core_sleep;
    assign wake_cause_o = r_wake_cause;
    assign sleep_cnt_o  = r_sleep_cnt;

endmodule

// File: tb/tb_core_sleep_ctrl.sv
// tb_core_sleep_ctrl: directed bench for core_sleep_ctrl with a
// cycle-level behavioural model checked every cycle.
module tb_core_sleep_ctrl;

    localparam int IDLE_N = 4;
    localparam int WAKE_N = 2;

    localparam int M_BOOT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_SLEEP = 3;
    localparam int M_WAKE  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fe = 1'b0;
    logic sreq = 1'b0;
    logic idle = 1'b0;
    logic irq = 1'b0;
    logic dbg = 1'b0;
    logic clr = 1'b0;

    logic        ce;
    logic        cs;
    logic [1:0]  cause;
    logic [31:0] cnt32;
    logic        ce4;
    logic        cs4;
    logic [1:0]  cause4;
    logic [3:0]  cnt4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    core_sleep_ctrl #(
        .IDLE_CYCLES(IDLE_N),
        .WAKE_CYCLES(WAKE_N),
        .CNT_WIDTH(32)
    ) u_dut (
        .clk_i(clk),
        .rst_i(rst),
        .fetch_enable_i(fe),
        .sleep_req_i(sreq),
        .pipe_idle_i(idle),
        .irq_pending_i(irq),
        .debug_req_i(dbg),
        .cnt_clr_i(clr),
        .clock_en_o(ce),
        .core_sleep_o(cs),
        .wake_cause_o(cause),
        .sleep_cnt_o(cnt32)
    );

    core_sleep_ctrl #(
        .IDLE_CYCLES(IDLE_N),
        .WAKE_CYCLES(WAKE_N),
        .CNT_WIDTH(4)
    ) u_dut4 (
        .clk_i(clk),
        .rst_i(rst),
        .fetch_enable_i(fe),
        .sleep_req_i(sreq),
        .pipe_idle_i(idle),
        .irq_pending_i(irq),
        .debug_req_i(dbg),
        .cnt_clr_i(clr),
        .clock_en_o(ce4),
        .core_sleep_o(cs4),
        .wake_cause_o(cause4),
        .sleep_cnt_o(cnt4)
    );

    // Model: mode plus elapsed counts (idle cycles seen, wake cycles
    // spent) and the two saturating sleep counters.
    int     m_mode;
    int     m_idle;
    int     m_wsn;
    int     m_cause;
    longint m_c32;
    longint m_c4;

    int     n_mode;
    int     n_idle;
    int     n_wsn;
    int     n_cause;
    longint n_c32;
    longint n_c4;

    always_comb begin
        n_mode  = m_mode;
        n_idle  = m_idle;
        n_wsn   = m_wsn;
        n_cause = m_cause;
        n_c32   = m_c32;
        n_c4    = m_c4;
        case (m_mode)
            M_BOOT: begin
                if (fe) begin
                    n_mode = M_WAKE;
                    n_wsn  = 0;
                end
            end
            M_RUN: begin
                if (sreq && !(irq || dbg)) begin
                    n_mode = M_DRAIN;
                    n_idle = 0;
                end
            end
            M_DRAIN: begin
                if (irq || dbg || !sreq) begin
                    n_mode = M_RUN;
                end else if (!idle) begin
                    n_idle = 0;
                end else begin
                    n_idle = m_idle + 1;
                    if (n_idle == IDLE_N) n_mode = M_SLEEP;
                end
            end
            M_SLEEP: begin
                if (irq || dbg) begin
                    n_mode  = M_WAKE;
                    n_wsn   = 0;
                    n_cause = (dbg ? 2 : 0) + (irq ? 1 : 0);
                end
            end
            M_WAKE: begin
                n_wsn = m_wsn + 1;
                if (n_wsn == WAKE_N) n_mode = M_RUN;
            end
            default: n_mode = M_BOOT;
        endcase
        if (clr) begin
            n_c32 = 0;
            n_c4  = 0;
        end else if (m_mode == M_SLEEP) begin
            if (m_c32 < 64'hFFFF_FFFF) n_c32 = m_c32 + 1;
            if (m_c4 < 15) n_c4 = m_c4 + 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode  <= M_BOOT;
            m_idle  <= 0;
            m_wsn   <= 0;
            m_cause <= 0;
            m_c32   <= 0;
            m_c4    <= 0;
        end else begin
            m_mode  <= n_mode;
            m_idle  <= n_idle;
            m_wsn   <= n_wsn;
            m_cause <= n_cause;
            m_c32   <= n_c32;
            m_c4    <= n_c4;
        end
    end

    task automatic check(input string name, input longint act,
                         input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int e_ce;
        int e_cs;
        e_ce = (m_mode == M_RUN || m_mode == M_DRAIN ||
                m_mode == M_WAKE) ? 1 : 0;
        e_cs = (m_mode == M_BOOT || m_mode == M_SLEEP ||
                m_mode == M_WAKE) ? 1 : 0;
        check("m_clock_en", longint'(ce), e_ce);
        check("m_core_sleep", longint'(cs), e_cs);
        check("m_wake_cause", longint'(cause), m_cause);
        check("m_cnt32", longint'(cnt32), m_c32);
        check("m_clock_en4", longint'(ce4), e_ce);
        check("m_core_sleep4", longint'(cs4), e_cs);
        check("m_wake_cause4", longint'(cause4), m_cause);
        check("m_cnt4", longint'(cnt4), m_c4);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            check_model();
        end
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        check("rst_ce", longint'(ce), 0);
        check("rst_cs", longint'(cs), 1);
        check("rst_cnt", longint'(cnt32), 0);
        check("rst_cause", longint'(cause), 0);

        // Boot
        tick(3);
        check("boot_wait_ce", longint'(ce), 0);
        fe = 1'b1;
        tick(1);
        fe = 1'b0;
        check("boot_wake_ce", longint'(ce), 1);
        check("boot_wake_cs", longint'(cs), 1);
        tick(1);
        check("boot_wake2_cs", longint'(cs), 1);
        tick(1);
        check("boot_run_cs", longint'(cs), 0);

        // Clean sleep
        sreq = 1'b1;
        idle = 1'b1;
        tick(4);
        check("drain_ce", longint'(ce), 1);
        tick(1);
        check("sleep_ce", longint'(ce), 0);
        check("sleep_cs", longint'(cs), 1);
        tick(10);
        check("cnt10", longint'(cnt32), 10);

        // Debug pulse wake
        sreq = 1'b0;
        dbg = 1'b1;
        tick(1);
        dbg = 1'b0;
        check("dbg_ce", longint'(ce), 1);
        check("dbg_cause", longint'(cause), 2);
        check("dbg_cnt", longint'(cnt32), 11);
        tick(1);
        check("dbg_wake_cs", longint'(cs), 1);
        tick(1);
        check("dbg_run_cs", longint'(cs), 0);

        // Drain with one non-idle cycle
        sreq = 1'b1;
        idle = 1'b1;
        tick(4);
        idle = 1'b0;
        tick(1);
        check("reload_ce", longint'(ce), 1);
        idle = 1'b1;
        tick(3);
        check("reload_ce2", longint'(ce), 1);
        tick(1);
        check("reload_sleep", longint'(ce), 0);

        // Saturation and clear
        tick(20);
        check("cnt31", longint'(cnt32), 31);
        check("cnt4_sat", longint'(cnt4), 15);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_cnt", longint'(cnt32), 0);
        check("clr_cnt4", longint'(cnt4), 0);
        tick(1);
        check("resume_cnt", longint'(cnt4), 1);

        // irq + debug together
        sreq = 1'b0;
        irq = 1'b1;
        dbg = 1'b1;
        tick(1);
        irq = 1'b0;
        dbg = 1'b0;
        check("both_cause", longint'(cause), 3);
        tick(2);
        check("both_run_cs", longint'(cs), 0);

        // irq during DRAIN aborts; sleep+wake stays in RUN
        sreq = 1'b1;
        idle = 1'b1;
        tick(2);
        irq = 1'b1;
        tick(1);
        check("abort_ce", longint'(ce), 1);
        check("abort_cs", longint'(cs), 0);
        tick(3);
        check("hold_run_ce", longint'(ce), 1);
        irq = 1'b0;
        sreq = 1'b0;
        tick(1);

        // Async reset mid-SLEEP
        sreq = 1'b1;
        tick(5);
        check("sleep2_ce", longint'(ce), 0);
        tick(3);
        sreq = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ars_ce", longint'(ce), 0);
        check("ars_cs", longint'(cs), 1);
        check("ars_cnt", longint'(cnt32), 0);
        check("ars_cause", longint'(cause), 0);
        check_model();
        @(negedge clk);
        rst = 1'b0;
        tick(3);
        check("need_fe_ce", longint'(ce), 0);

        // Async reset mid-WAKE
        fe = 1'b1;
        tick(1);
        fe = 1'b0;
        check("wake3_ce", longint'(ce), 1);
        #2 rst = 1'b1;
        #1;
        check("arw_ce", longint'(ce), 0);
        check("arw_cs", longint'(cs), 1);
        check_model();
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        check("need_fe2_ce", longint'(ce), 0);
        fe = 1'b1;
        tick(3);
        fe = 1'b0;
        check("reboot_cs", longint'(cs), 0);
        check("reboot_ce", longint'(ce), 1);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
